// File: rtl/fpu_stack_ctrl.sv
// FPU stack controller: TOP/tag bookkeeping and register-file sequencing for the 8-deep x87 stack.
// Optional macro FPU_STACK_TAGCLASS_EN enables data-dependent tag classification on writes.
module fpu_stack_ctrl #(
    parameter int                DATA_W     = 80,
    parameter logic [DATA_W-1:0] QNAN_INDEF = 80'hFFFF_C000_0000_0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [2:0]        cmd_idx,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [2:0]        rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic [2:0]        top,
    output logic [15:0]       tag_word,
    output logic              stack_fault,
    output logic              fault_c1
);
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_WRITE = 3'd4;
    localparam logic [2:0] OP_FXCH  = 3'd5;
    localparam logic [2:0] OP_FREE  = 3'd6;
    localparam logic [2:0] OP_INIT  = 3'd7;

    localparam logic [1:0] TAG_VALID   = 2'b00;
    localparam logic [1:0] TAG_SPECIAL = 2'b10;
    localparam logic [1:0] TAG_EMPTY   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_XCH_A = 3'd2,
        ST_XCH_B = 3'd3,
        ST_XCH_C = 3'd4
    } state_t;

`ifdef FPU_STACK_TAGCLASS_EN
    function automatic logic [1:0] tag_class(input logic [DATA_W-1:0] x);
        logic [1:0] cls;
        if (x[78:0] == 79'd0) begin
            cls = 2'b01;
        end else if (x[78:64] == 15'h7FFF) begin
            cls = TAG_SPECIAL;
        end else if (!x[63] && (x[78:64] != 15'd0)) begin
            cls = TAG_SPECIAL;
        end else begin
            cls = TAG_VALID;
        end
        return cls;
    endfunction
`endif

    // An empty operand of an exchange comes back as the indefinite NaN, tagged special.
    function automatic logic [1:0] xch_tag(input logic [1:0] t);
        return (t == TAG_EMPTY) ? TAG_SPECIAL : t;
    endfunction

    state_t            state_r;
    logic [2:0]        op_r;
    logic [2:0]        idx_r;
    logic [1:0]        cls_r;
    logic [2:0]        top_r;
    logic [15:0]       tag_word_r;
    logic              fault_r;
    logic              c1_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [2:0]        rd_addr_r;
    logic [2:0]        wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              we_r;
    logic              ready_r;

    logic [2:0]        push_p_s;
    logic [2:0]        cmd_st_s;
    logic [2:0]        op_st_s;
    logic [1:0]        tag_push_s;
    logic [1:0]        tag_top_s;
    logic [1:0]        tag_op_st_s;
    logic [1:0]        rd_tag_s;
    logic              rd_empty_s;
    logic [DATA_W-1:0] rd_val_s;
    logic [1:0]        cmd_cls_s;

    // Address arithmetic, tag lookups and the underflow-substituted read value.
    always_comb begin
        push_p_s    = top_r - 3'd1;
        cmd_st_s    = top_r + cmd_idx;
        op_st_s     = top_r + idx_r;
        tag_push_s  = tag_word_r[{push_p_s, 1'b0} +: 2];
        tag_top_s   = tag_word_r[{top_r, 1'b0} +: 2];
        tag_op_st_s = tag_word_r[{op_st_s, 1'b0} +: 2];
        if ((state_r == ST_XCH_B) || (op_r == OP_POP)) begin
            rd_tag_s = tag_top_s;
        end else begin
            rd_tag_s = tag_op_st_s;
        end
        rd_empty_s = (rd_tag_s == TAG_EMPTY);
        if (rd_empty_s) begin
            rd_val_s = QNAN_INDEF;
        end else begin
            rd_val_s = rf_read_data;
        end
`ifdef FPU_STACK_TAGCLASS_EN
        cmd_cls_s = tag_class(cmd_data);
`else
        cmd_cls_s = TAG_VALID;
`endif
    end

    // Command sequencer: register-file strobes are set up on acceptance, state commits at the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NOP;
            idx_r       <= 3'd0;
            cls_r       <= TAG_VALID;
            top_r       <= 3'd0;
            tag_word_r  <= 16'hFFFF;
            fault_r     <= 1'b0;
            c1_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rd_addr_r   <= 3'd0;
            wr_addr_r   <= 3'd0;
            wr_data_r   <= {DATA_W{1'b0}};
            we_r        <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    we_r <= 1'b0;
                    if (cmd_valid && ready_r) begin
                        op_r    <= cmd_op;
                        idx_r   <= cmd_idx;
                        cls_r   <= cmd_cls_s;
                        state_r <= ST_EXEC;
                        ready_r <= 1'b0;
                        case (cmd_op)
                            OP_PUSH: begin
                                we_r      <= 1'b1;
                                wr_addr_r <= push_p_s;
                                wr_data_r <= (tag_push_s == TAG_EMPTY) ? cmd_data : QNAN_INDEF;
                            end
                            OP_POP:   rd_addr_r <= top_r;
                            OP_READ:  rd_addr_r <= cmd_st_s;
                            OP_WRITE: begin
                                we_r      <= 1'b1;
                                wr_addr_r <= cmd_st_s;
                                wr_data_r <= cmd_data;
                            end
                            OP_FXCH: begin
                                rd_addr_r <= cmd_st_s;
                                state_r   <= ST_XCH_A;
                            end
                            OP_FREE, OP_INIT: ;
                            default: begin
                                state_r <= ST_IDLE;
                                ready_r <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    we_r    <= 1'b0;
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    case (op_r)
                        OP_PUSH: begin
                            top_r <= push_p_s;
                            if (tag_push_s == TAG_EMPTY) begin
                                tag_word_r[{push_p_s, 1'b0} +: 2] <= cls_r;
                            end else begin
                                tag_word_r[{push_p_s, 1'b0} +: 2] <= TAG_SPECIAL;
                                fault_r <= 1'b1;
                                c1_r    <= 1'b1;
                            end
                        end
                        OP_POP, OP_READ: begin
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= rd_val_s;
                            if (rd_empty_s) begin
                                fault_r <= 1'b1;
                                c1_r    <= 1'b0;
                            end
                            if (op_r == OP_POP) begin
                                tag_word_r[{top_r, 1'b0} +: 2] <= TAG_EMPTY;
                                top_r <= top_r + 3'd1;
                            end
                        end
                        OP_WRITE: tag_word_r[{op_st_s, 1'b0} +: 2] <= cls_r;
                        OP_FREE:  tag_word_r[{op_st_s, 1'b0} +: 2] <= TAG_EMPTY;
                        OP_INIT: begin
                            top_r      <= 3'd0;
                            tag_word_r <= 16'hFFFF;
                            fault_r    <= 1'b0;
                            c1_r       <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_XCH_A: begin
                    rd_addr_r <= top_r;
                    we_r      <= 1'b1;
                    wr_addr_r <= top_r;
                    wr_data_r <= rd_val_s;
                    state_r   <= ST_XCH_B;
                end
                ST_XCH_B: begin
                    we_r      <= 1'b1;
                    wr_addr_r <= op_st_s;
                    wr_data_r <= rd_val_s;
                    state_r   <= ST_XCH_C;
                end
                ST_XCH_C: begin
                    we_r    <= 1'b0;
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    tag_word_r[{top_r, 1'b0} +: 2]   <= xch_tag(tag_op_st_s);
                    tag_word_r[{op_st_s, 1'b0} +: 2] <= xch_tag(tag_top_s);
                    if ((tag_top_s == TAG_EMPTY) || (tag_op_st_s == TAG_EMPTY)) begin
                        fault_r <= 1'b1;
                        c1_r    <= 1'b0;
                    end
                end
                default: begin
                    we_r    <= 1'b0;
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready       = ready_r;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_data        = rsp_data_r;
    assign rf_read_addr    = rd_addr_r;
    assign rf_write_addr   = wr_addr_r;
    assign rf_write_data   = wr_data_r;
    assign rf_write_enable = we_r;
    assign top             = top_r;
    assign tag_word        = tag_word_r;
    assign stack_fault     = fault_r;
    assign fault_c1        = c1_r;
endmodule

// File: tb/tb_fpu_stack_ctrl.sv
// Self-checking bench for fpu_stack_ctrl: stack-level reference model, per-cycle compare, directed + random stimulus.
module tb_fpu_stack_ctrl;
    localparam logic [79:0] QNAN = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_READ = 3'd3;
    localparam logic [2:0] OP_WRITE = 3'd4, OP_FXCH = 3'd5, OP_FREE = 3'd6, OP_INIT = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [2:0]  cmd_idx = 3'd0;
    logic [79:0] cmd_data = 80'd0;
    logic        rsp_valid;
    logic [79:0] rsp_data;
    logic [2:0]  rf_read_addr;
    logic [79:0] rf_read_data;
    logic [2:0]  rf_write_addr;
    logic [79:0] rf_write_data;
    logic        rf_write_enable;
    logic [2:0]  top;
    logic [15:0] tag_word;
    logic        stack_fault;
    logic        fault_c1;

    fpu_stack_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable), .top(top), .tag_word(tag_word),
        .stack_fault(stack_fault), .fault_c1(fault_c1)
    );

    always #5 clk = ~clk;

    // Register file: write at posedge, combinational read.
    logic [79:0] rf_mem [8];
    always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
    assign rf_read_data = rf_mem[rf_read_addr];

    // Reference model state (stack semantics, not cycle structure).
    int          m_top;
    logic [1:0]  m_tag [8];
    logic [79:0] m_phys [8];
    bit          m_known [8];
    bit          m_fault, m_c1;
    bit          exp_ready, exp_rsp_valid;
    logic [79:0] exp_rsp_data;
    bit          check_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          busy_len;
    logic        first_we;
    logic [2:0]  first_waddr;
    logic [79:0] last_rsp;
    logic        last_rsp_valid;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_cls(input logic [79:0] v);
        logic [1:0] c;
        c = 2'b00;
`ifdef FPU_STACK_TAGCLASS_EN
        if (v[78:0] == 79'd0) c = 2'b01;
        else if (v[78:64] == 15'h7FFF || (v[63] == 1'b0 && v[78:64] != 15'd0)) c = 2'b10;
`else
        if (v === 80'bx) c = 2'b00;
`endif
        return c;
    endfunction

    function automatic logic [15:0] model_tag_word();
        logic [15:0] w;
        for (int i = 0; i < 8; i++) w[2*i +: 2] = m_tag[i];
        return w;
    endfunction

    task automatic model_reset();
        m_top = 0; m_fault = 1'b0; m_c1 = 1'b0;
        for (int i = 0; i < 8; i++) begin m_tag[i] = 2'b11; m_known[i] = 1'b0; end
        exp_ready = 1'b1; exp_rsp_valid = 1'b0; exp_rsp_data = 80'd0;
    endtask

    // Architectural effect of one command on the stack.
    task automatic model_exec(input logic [2:0] op, input logic [2:0] idx, input logic [79:0] d,
                              output logic [79:0] rsp);
        int a, b;
        logic [79:0] va, vb;
        logic [1:0] ta, tb;
        a = m_top; b = (m_top + int'(idx)) % 8; rsp = 80'd0;
        case (op)
            OP_PUSH: begin
                a = (m_top + 7) % 8;
                if (m_tag[a] == 2'b11) begin m_phys[a] = d; m_tag[a] = model_cls(d); end
                else begin m_phys[a] = QNAN; m_tag[a] = 2'b10; m_fault = 1'b1; m_c1 = 1'b1; end
                m_known[a] = 1'b1; m_top = a;
            end
            OP_POP, OP_READ: begin
                if (op == OP_READ) a = b;
                if (m_tag[a] == 2'b11) begin rsp = QNAN; m_fault = 1'b1; m_c1 = 1'b0; end
                else rsp = m_phys[a];
                if (op == OP_POP) begin m_tag[a] = 2'b11; m_top = (m_top + 1) % 8; end
            end
            OP_WRITE: begin m_phys[b] = d; m_tag[b] = model_cls(d); m_known[b] = 1'b1; end
            OP_FREE: m_tag[b] = 2'b11;
            OP_INIT: begin
                m_top = 0; m_fault = 1'b0; m_c1 = 1'b0;
                for (int i = 0; i < 8; i++) m_tag[i] = 2'b11;
            end
            OP_FXCH: begin
                va = (m_tag[a] == 2'b11) ? QNAN : m_phys[a];
                vb = (m_tag[b] == 2'b11) ? QNAN : m_phys[b];
                ta = (m_tag[a] == 2'b11) ? 2'b10 : m_tag[a];
                tb = (m_tag[b] == 2'b11) ? 2'b10 : m_tag[b];
                if (m_tag[a] == 2'b11 || m_tag[b] == 2'b11) begin m_fault = 1'b1; m_c1 = 1'b0; end
                m_phys[a] = vb; m_phys[b] = va; m_tag[a] = tb; m_tag[b] = ta;
                m_known[a] = 1'b1; m_known[b] = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Single compare process: every cycle against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cmd_ready", 80'(cmd_ready), 80'(exp_ready));
            chk("top", 80'(top), 80'(m_top));
            chk("tag_word", 80'(tag_word), 80'(model_tag_word()));
            chk("stack_fault", 80'(stack_fault), 80'(m_fault));
            chk("fault_c1", 80'(fault_c1), 80'(m_c1));
            chk("rsp_valid", 80'(rsp_valid), 80'(exp_rsp_valid));
            if (exp_rsp_valid) chk("rsp_data", rsp_data, exp_rsp_data);
            if (exp_ready) begin
                chk("idle_we", 80'(rf_write_enable), 80'd0);
                for (int i = 0; i < 8; i++)
                    if (m_known[i]) chk("rf_content", rf_mem[i], m_phys[i]);
            end
        end
    end

    function automatic logic [79:0] rand_data();
        logic [95:0] r;
        logic [79:0] d;
        r = {$urandom, $urandom, $urandom};
        d = r[79:0];
        case ($urandom_range(0, 4))
            0: d = {d[79], 79'd0};
            1: d[78:64] = 15'h7FFF;
            2: begin d[63] = 1'b0; if (d[78:64] == 15'd0) d[64] = 1'b1; end
            3: begin d[78:64] = 15'h3FFF; d[63] = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    // Issue one command at an idle cycle; random junk is presented while busy and must be ignored.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [79:0] d);
        int n;
        logic [79:0] rsp;
        n = (op == OP_NOP) ? 0 : ((op == OP_FXCH) ? 3 : 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; exp_rsp_valid = 1'b0; busy_len = 0;
        if (n > 0) begin
            exp_ready = 1'b0;
            first_we = rf_write_enable; first_waddr = rf_write_addr;
            for (int k = 0; k < n; k++) begin
                if (!cmd_ready) busy_len++;
                cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 3'($urandom);
                cmd_idx = 3'($urandom); cmd_data = rand_data();
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            chk("busy_len", 80'(busy_len), 80'(n));
            model_exec(op, idx, d, rsp);
            exp_ready = 1'b1;
            if (op == OP_POP || op == OP_READ) begin exp_rsp_valid = 1'b1; exp_rsp_data = rsp; end
            last_rsp = rsp_data; last_rsp_valid = rsp_valid;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; exp_rsp_valid = 1'b0; end
    endtask

    localparam logic [79:0] VAL_A = 80'h3FFF_8000_0000_0000_0000;
    localparam logic [79:0] VAL_B = 80'h4000_C000_0000_0000_1234;

    initial begin
        int r;
        logic [2:0] op;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_top", 80'(top), 80'd0);
        chk("rst_tag", 80'(tag_word), 80'hFFFF);
        chk("rst_ready", 80'(cmd_ready), 80'd1);
        chk("rst_fault", 80'({stack_fault, fault_c1}), 80'd0);
        chk("rst_rsp", 80'(rsp_valid), 80'd0);
        chk("rst_rsp_data", rsp_data, 80'd0);
        chk("rst_we", 80'(rf_write_enable), 80'd0);
        chk("rst_addr", 80'({rf_read_addr, rf_write_addr}), 80'd0);
        check_en = 1'b1;

        do_cmd(OP_PUSH, 3'd0, VAL_A);
        chk("push_we_exec", 80'(first_we), 80'd1);
        chk("push_waddr_exec", 80'(first_waddr), 80'd7);
        chk("push_top", 80'(top), 80'd7);
        chk("push_tag", 80'(tag_word), 80'h3FFF);
        chk("push_no_rsp", 80'(rsp_valid), 80'd0);

        do_cmd(OP_POP, 3'd0, 80'd0);
        chk("pop_rsp_valid", 80'(last_rsp_valid), 80'd1);
        chk("pop_data", last_rsp, VAL_A);
        chk("pop_top_tag", 80'({top, tag_word, stack_fault}), 80'({3'd0, 16'hFFFF, 1'b0}));

        do_cmd(OP_POP, 3'd0, 80'd0);
        chk("uflow_data", last_rsp, QNAN);
        chk("uflow_flags", 80'({top, stack_fault, fault_c1}), 80'({3'd1, 1'b1, 1'b0}));
        do_cmd(OP_INIT, 3'd0, 80'd0);
        chk("init_state", 80'({top, stack_fault, fault_c1, tag_word}), 80'({3'd0, 1'b0, 1'b0, 16'hFFFF}));

        for (int j = 0; j < 9; j++) do_cmd(OP_PUSH, 3'd0, VAL_B + 80'(j));
        chk("oflow_flags", 80'({top, stack_fault, fault_c1}), 80'({3'd7, 1'b1, 1'b1}));
        chk("oflow_qnan", rf_mem[7], QNAN);

        do_cmd(OP_INIT, 3'd0, 80'd0);
        do_cmd(OP_PUSH, 3'd0, VAL_A);
        do_cmd(OP_PUSH, 3'd0, VAL_B);
        do_cmd(OP_FXCH, 3'd1, 80'd0);
        chk("fxch_busy3", 80'(busy_len), 80'd3);
        do_cmd(OP_READ, 3'd0, 80'd0);
        chk("fxch_st0", last_rsp, VAL_A);
        do_cmd(OP_READ, 3'd1, 80'd0);
        chk("fxch_st1", last_rsp, VAL_B);
        idle(1);

        check_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_FXCH; cmd_idx = 3'd1; cmd_data = 80'd0;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("xchb_we", 80'(rf_write_enable), 80'd1);
        reset = 1'b1; #1;
        chk("rst_mid_we", 80'(rf_write_enable), 80'd0);
        chk("rst_mid_state", 80'({top, tag_word}), 80'({3'd0, 16'hFFFF}));
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready", 80'(cmd_ready), 80'd1);
        check_en = 1'b1;

        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            if (r < 25) op = OP_PUSH;
            else if (r < 45) op = OP_POP;
            else if (r < 60) op = OP_READ;
            else if (r < 70) op = OP_WRITE;
            else if (r < 82) op = OP_FXCH;
            else if (r < 90) op = OP_FREE;
            else if (r < 93) op = OP_INIT;
            else op = OP_NOP;
            do_cmd(op, 3'($urandom), rand_data());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpu_stack_ctrl.md
Name: fpu_stack_ctrl

Overview:
Initiator side of the 8-entry x 80-bit FPU stack register file. It accepts stack-level commands (push, pop, read/write ST(i), exchange, free, init) and maintains the TOP pointer and the 16-bit tag word. It translates each command into physical read/write cycles on the register file port and flags stack overflow/underflow. It sits between the FPU microsequencer and the register file.

Parameters:
DATA_W, 80, register width
QNAN_INDEF, 80'hFFFF_C000_0000_0000_0000, value returned on underflow reads

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  3  0 NOP,1 PUSH,2 POP,3 READ_ST,4 WRITE_ST,5 FXCH,6 FREE,7 INIT
cmd_idx  in  3  stack-relative index i for ST(i)
cmd_data  in  80  data for PUSH/WRITE_ST
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_data  out  80  data for POP/READ_ST
rf_read_addr  out  3  physical read address to register file
rf_read_data  in  80  register file combinational read data
rf_write_addr  out  3  physical write address
rf_write_data  out  80  write data
rf_write_enable  out  1  write strobe, sampled at next posedge
top  out  3  current TOP
tag_word  out  16  tag for physical reg n at bits [2n+1:2n]; 00 valid, 01 zero, 10 special, 11 empty
stack_fault  out  1  sticky fault flag
fault_c1  out  1  1 = overflow, 0 = underflow (last fault)

Behaviour:
- Reset: async. State IDLE, top=0, tag_word=16'hFFFF, stack_fault=0, fault_c1=0, rsp_valid=0, rsp_data=0, rf_write_enable=0, rf addresses 0, cmd_ready=1 once reset deasserts. Reset mid-command aborts with no further rf writes.
- Physical address of ST(i) = (top + i) mod 8, 3-bit wrap.
- Handshake: command accepted on posedge with cmd_valid && cmd_ready. cmd_op, cmd_idx and cmd_data are latched. NOP is accepted and ignored.
- States: IDLE, EXEC, XCH_A, XCH_B, XCH_C.
- Single-step ops (PUSH, POP, READ_ST, WRITE_ST, FREE, INIT): IDLE -> EXEC (1 cycle) -> IDLE. cmd_ready is low in EXEC, so throughput is 1 command per 2 cycles.
- PUSH in EXEC: p=(top-1) mod 8.
  - Tag[p]==11: rf write of cmd_data to p, tag[p]=class(cmd_data), top=p.
  - Tag[p]!=11: overflow. stack_fault=1, fault_c1=1, top=p, write QNAN_INDEF to p, tag[p]=10.
- POP in EXEC: rf_read_addr=top.
  - Tag[top]!=11: rsp_data=rf_read_data.
  - Tag[top]==11: underflow. rsp_data=QNAN_INDEF, stack_fault=1, fault_c1=0.
  - In both cases: tag[top]=11, top=top+1, rsp_valid pulses in the cycle after EXEC.
- READ_ST in EXEC: same read path as POP but for ST(i). Underflow on an empty tag is handled as in POP. No tag/top change.
- WRITE_ST in EXEC: write cmd_data to ST(i), tag=class(cmd_data). Never faults.
- FREE: tag[ST(i)]=11, no rf access.
- INIT: top=0, tag_word=FFFF, stack_fault=0, fault_c1=0, no rf access.
- FXCH (ST(0) <-> ST(i)): IDLE->XCH_A->XCH_B->XCH_C->IDLE.
  - XCH_A: read ST(i) into tmp.
  - XCH_B: read ST(0) into tmp2; write tmp to ST(0). The read returns the pre-write value.
  - XCH_C: write tmp2 to ST(i); swap the two tags.
  - i=0: sequence still runs; data and tags end unchanged.
  - Either tag empty: underflow flagged, and the empty operand is replaced by QNAN_INDEF with tag 10.
- rf_write_enable is high only during the write cycle(s) above, otherwise 0. rf_write_data/addr are don't-care when it is 0.
- Faults are sticky until INIT or reset. fault_c1 reflects the most recent fault.

Optional Feature:
Macro FPU_STACK_TAGCLASS_EN.
- Defined: class(x) = 01 if x[78:0]==0; 10 if exponent x[78:64]==7FFF or integer bit x[63]==0 with nonzero exponent; else 00.
- Undefined: class(x)=00 for every write. Fault-generated writes still use tag 10.

Test Plan:
- Reset then PUSH cmd_data=80'h3FFF_8000_0000_0000_0000 -> rf write addr 7 in EXEC, top=7, tag_word=16'h3FFF, rsp_valid stays 0.
- PUSH A then POP -> rsp_valid 2 cycles after POP acceptance, rsp_data=A, top=0, tag_word=FFFF, stack_fault=0.
- POP on empty stack after reset -> rsp_data=QNAN_INDEF, stack_fault=1, fault_c1=0, top=1; INIT then clears to top=0, fault 0.
- Nine PUSHes -> 9th sets stack_fault=1, fault_c1=1, top=7, physical reg 7 contains QNAN_INDEF.
- PUSH A, PUSH B, FXCH i=1 -> cmd_ready low 3 cycles, READ_ST 0 returns A, READ_ST 1 returns B.
- Assert reset during XCH_B -> rf_write_enable drops immediately, top=0, tag_word=FFFF, cmd_ready=1 after release.
